// File: rtl/tcdm_id_pkg.sv
// Shared types for the TCDM ID memory adapter: reqrsp channel structs, response
// FIFO entries and latency-pipe entries.
package tcdm_id_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 2;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        amo_op_e              amo;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic [IdWidth-1:0]   id;
    } req_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 error;
    } rsp_chan_t;

    typedef struct packed {
        req_chan_t q;
        logic      q_valid;
        logic      p_ready;
    } dreq_t;

    typedef struct packed {
        logic      q_ready;
        rsp_chan_t p;
        logic      p_valid;
    } drsp_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } rsp_entry_t;

    typedef struct packed {
        logic               valid;
        logic [IdWidth-1:0] id;
        logic               write;
        logic               err;
    } pipe_entry_t;

    // Width able to hold every credit value 0..depth inclusive.
    function automatic int unsigned credit_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// Registered response FIFO (no fall-through) with full/empty/usage status.
module tcdm_rsp_fifo #(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = tcdm_id_pkg::rsp_entry_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       data_i,
    input  logic                         pop_i,
    output entry_t                       data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);
    import tcdm_id_pkg::*;

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UseW = $clog2(Depth + 1);

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [UseW-1:0]   usage_q;
    logic              do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (usage_q == UseW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only pointers and occupancy are control state.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   usage_q <= usage_q + 1'b1;
                2'b01:   usage_q <= usage_q - 1'b1;
                default: usage_q <= usage_q;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_id_mem_adapter.sv
// Bridges the remapped reqrsp stream onto a fixed-latency TCDM bank port, with
// credit-guarded response buffering so p_ready backpressure never drops data.
module tcdm_id_mem_adapter #(
    parameter int unsigned AddrWidth  = tcdm_id_pkg::AddrWidth,
    parameter int unsigned DataWidth  = tcdm_id_pkg::DataWidth,
    parameter int unsigned IdWidth    = tcdm_id_pkg::IdWidth,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned RspDepth   = 4,
    parameter type         dreq_t     = tcdm_id_pkg::dreq_t,
    parameter type         drsp_t     = tcdm_id_pkg::drsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  dreq_t                  slv_req_i,
    output drsp_t                  slv_rsp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);
    import tcdm_id_pkg::*;

    localparam int unsigned CredW = credit_width(RspDepth);

    if (MemLatency < 1 || MemLatency > 4) begin : g_bad_latency
        $error("MemLatency must be within 1..4");
    end

    logic [CredW-1:0]  credit_q, credit_d, usage;
    logic [IdWidth-1:0] req_id;
    pipe_entry_t       stage_p [MemLatency];
    pipe_entry_t       exit_entry;
    rsp_entry_t        push_entry, head;
    logic              is_amo, issue_ok, q_ready, hs;
    logic              push, pop, p_valid, full, empty;

    // Request side: AMOs bypass the bank and need no grant.
    assign req_id      = slv_req_i.q.id;
    assign is_amo      = (slv_req_i.q.amo != AMONone);
    assign issue_ok    = rst_ni && (credit_q != '0);
    assign mem_req_o   = slv_req_i.q_valid && issue_ok && !is_amo;
    assign q_ready     = issue_ok && (is_amo || mem_gnt_i);
    assign hs          = slv_req_i.q_valid && q_ready;
    assign mem_we_o    = slv_req_i.q.write;
    assign mem_addr_o  = slv_req_i.q.addr;
    assign mem_wdata_o = slv_req_i.q.data;
    assign mem_be_o    = slv_req_i.q.strb;

    // Latency pipe: shifts every cycle, valids are the only reset state.
    always_ff @(posedge clk_i) begin
        stage_p[0] <= '{valid: hs, id: req_id, write: slv_req_i.q.write, err: is_amo};
        for (int i = 1; i < int'(MemLatency); i++) stage_p[i] <= stage_p[i-1];
        if (!rst_ni) begin
            for (int i = 0; i < int'(MemLatency); i++) stage_p[i].valid <= 1'b0;
        end
    end

    // Pipe exit: only reads return bank data.
    assign exit_entry = stage_p[MemLatency-1];
    assign push       = exit_entry.valid;
    assign push_entry = '{data: (exit_entry.write || exit_entry.err) ? '0 : mem_rdata_i,
                          id:   exit_entry.id,
                          err:  exit_entry.err};

    tcdm_rsp_fifo #(
        .Depth   (RspDepth),
        .entry_t (rsp_entry_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage)
    );

    // Response side.
    assign p_valid = rst_ni && !empty;
    assign pop     = p_valid && slv_req_i.p_ready;

    always_comb begin
        slv_rsp_o         = '0;
        slv_rsp_o.q_ready = q_ready;
        slv_rsp_o.p_valid = p_valid;
        slv_rsp_o.p.data  = head.data;
        slv_rsp_o.p.id    = head.id;
        slv_rsp_o.p.error = head.err;
    end

    // Credits: free response slots minus entries still in the latency pipe.
    always_comb begin
        case ({hs, pop})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) credit_q <= CredW'(RspDepth);
        else         credit_q <= credit_d;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    a_credit_max:  assert property (@(posedge clk_i) disable iff (!rst_ni) credit_q <= CredW'(RspDepth));
    a_credit_min:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(hs && !pop && credit_q == '0));
    a_credit_sum:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    int'(credit_q) + int'(usage) <= int'(RspDepth));

endmodule

// File: tb/tb_tcdm_id_mem_adapter.sv
// Scoreboard bench for tcdm_id_mem_adapter (MemLatency=1, RspDepth=4).
module tb_tcdm_id_mem_adapter;
    import tcdm_id_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    dreq_t       req;
    drsp_t       rsp;
    logic        mem_req, mem_gnt, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_be;

    int vecs = 0;
    int errs = 0;

    rsp_entry_t  sb[$];
    rsp_entry_t  mon_exp;
    int          mcredit, mcnt;
    bit          mpipe_v;
    logic [63:0] rdata_next;

    always #5 clk = ~clk;

    tcdm_id_mem_adapter #(
        .MemLatency (1),
        .RspDepth   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .slv_req_i   (req),
        .slv_rsp_o   (rsp),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected handshake/valid behaviour comes from
    // a small credit/FIFO model of the adapter kept in the bench.
    task automatic cyc(input bit qv, input bit wr, input amo_op_e amo, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] strb, input logic [1:0] id,
                       input bit gnt, input bit pr);
        bit eq, er, ev, hs, pop;
        rsp_entry_t e;
        @(negedge clk);
        mem_rdata      = rdata_next;
        req.q_valid    = qv;
        req.q.write    = wr;
        req.q.amo      = amo;
        req.q.addr     = addr;
        req.q.data     = data;
        req.q.strb     = strb;
        req.q.id       = id;
        req.p_ready    = pr;
        mem_gnt        = gnt;
        #1;
        eq = (mcredit != 0) && (amo != AMONone || gnt);
        er = qv && (mcredit != 0) && (amo == AMONone);
        ev = (mcnt != 0);
        check("q_ready", 64'(rsp.q_ready), 64'(eq));
        check("mem_req", 64'(mem_req), 64'(er));
        check("p_valid", 64'(rsp.p_valid), 64'(ev));
        if (er) begin
            check("mem_we",   64'(mem_we), 64'(wr));
            check("mem_addr", 64'(mem_addr), 64'(addr));
            check("mem_be",   64'(mem_be), 64'(strb));
            if (wr) check("mem_wdata", mem_wdata, data);
        end
        hs  = qv && eq;
        pop = ev && pr;
        if (hs) begin
            e.data = (wr || amo != AMONone) ? 64'h0 : data;
            e.id   = id;
            e.err  = (amo != AMONone);
            sb.push_back(e);
        end
        rdata_next = (hs && !wr && amo == AMONone) ? data : 64'hBAD0_BAD0_BAD0_BAD0;
        mcnt    = mcnt + int'(mpipe_v) - int'(pop);
        mpipe_v = hs;
        mcredit = mcredit + int'(pop) - int'(hs);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] id,
                      input bit gnt, input bit pr);
        cyc(1'b1, 1'b0, AMONone, addr, data, 8'hFF, id, gnt, pr);
    endtask

    task automatic idle(input int n, input bit pr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, AMONone, 32'h0, 64'h0, 8'h0, 2'd0, 1'b1, pr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni      = 1'b0;
        req.q_valid = 1'b1;
        req.q.amo   = AMONone;
        req.p_ready = 1'b1;
        mem_gnt     = 1'b1;
        #1;
        check("rst_q_ready", 64'(rsp.q_ready), 64'h0);
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_p_valid", 64'(rsp.p_valid), 64'h0);
        sb.delete();
        mcredit    = 4;
        mcnt       = 0;
        mpipe_v    = 1'b0;
        rdata_next = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        rst_ni      = 1'b1;
        req.q_valid = 1'b0;
    endtask

    // Monitor: every accepted response must match the oldest outstanding request.
    always @(negedge clk) begin
        #2;
        if (rst_ni && rsp.p_valid && req.p_ready) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL stale_rsp: got id %0d data %0h, expected no response", rsp.p.id, rsp.p.data);
            end else begin
                mon_exp = sb.pop_front();
                check("rsp_id",    64'(rsp.p.id), 64'(mon_exp.id));
                check("rsp_data",  rsp.p.data, mon_exp.data);
                check("rsp_error", 64'(rsp.p.error), 64'(mon_exp.err));
            end
        end
    end

    initial begin
        req        = '0;
        mem_gnt    = 1'b0;
        mem_rdata  = '0;
        rdata_next = 64'hBAD0_BAD0_BAD0_BAD0;
        mcredit    = 4;
        mcnt       = 0;
        mpipe_v    = 1'b0;
        do_reset();

        // Single read, response two cycles after handshake.
        rd(32'h100, 64'hDEAD_BEEF, 2'd2, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Back-to-back reads, one per cycle.
        for (int i = 0; i < 4; i++) rd(32'h200 + 32'(i * 8), 64'h1111_0000 + 64'(i), 2'(i), 1'b1, 1'b1);
        idle(4, 1'b1);

        // Backpressure: credits run out after four handshakes.
        for (int i = 0; i < 6; i++) rd(32'h300 + 32'(i * 8), 64'h2222_0000 + 64'(i), 2'(i), 1'b1, 1'b0);
        rd(32'h340, 64'h2222_0006, 2'd2, 1'b1, 1'b1);
        rd(32'h348, 64'h2222_0007, 2'd3, 1'b1, 1'b0);
        rd(32'h350, 64'h2222_0008, 2'd0, 1'b1, 1'b0);
        idle(8, 1'b1);

        // Grant withheld for three cycles.
        for (int i = 0; i < 3; i++) rd(32'h400, 64'h3333_4444, 2'd1, 1'b0, 1'b1);
        rd(32'h400, 64'h3333_4444, 2'd1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Write then unsupported AMO.
        cyc(1'b1, 1'b1, AMONone, 32'h500, 64'h1234_5678, 8'h0F, 2'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, AMOAdd,  32'h508, 64'h9999_9999, 8'hFF, 2'd3, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Reset with buffered responses; none may reappear.
        for (int i = 0; i < 3; i++) rd(32'h600 + 32'(i * 8), 64'h5555_0000 + 64'(i), 2'(i), 1'b1, 1'b0);
        idle(2, 1'b0);
        do_reset();
        idle(5, 1'b1);
        rd(32'h700, 64'hCAFE_F00D, 2'd3, 1'b1, 1'b1);
        idle(4, 1'b1);

        @(negedge clk);
        #3;
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
